pll_lock_ctrl: RTL
==================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 16: cycles `pll_rst` is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 2700000: cycles allowed for lock after a reset pulse (100 ms at 27 MHz).
REQ-003 SHALL have parameter HOLDOFF_CYC, default 270: cycles lock must stay continuously high before ready (10 us at 27 MHz).
REQ-004 SHALL have parameter LOSS_FILT_CYC, default 4: consecutive low synced-lock samples that count as lock loss.
REQ-005 SHALL have parameter MAX_RETRY, default 7: lock timeouts tolerated before fault.
REQ-006 SHALL have port `clk_27m` (input, 1): free-running 27 MHz board clock; the only clock.
REQ-007 SHALL have port `rst_n` (input, 1): asynchronous, active-low reset.
REQ-008 SHALL have port `pll_locked` (input, 1): raw PLL lock, asynchronous to `clk_27m`.
REQ-009 SHALL have port `pll_rst` (output, 1): active-high reset to the PLL RESET pin.
REQ-010 SHALL have port `clk_ready` (output, 1): the PLL clocks are stable and usable.
REQ-011 SHALL have port `fault` (output, 1): retries exhausted; sticky until `rst_n`.
REQ-012 SHALL have port `retry_cnt` (output, 3): lock timeouts since reset, saturating at 7.
REQ-013 SHALL have port `loss_cnt` (output, 8): lock-loss events while in RUN, saturating at 255.

Function
REQ-014 SHALL pass `pll_locked` through a 2-flop synchronizer; all logic SHALL use only the synced value `lk`.
REQ-015 SHALL implement states RST_PLL, WAIT_LOCK, HOLDOFF, RUN and FAULT with one shared down-counter `tmr` (width = clog2 of the largest parameter).
REQ-016 SHALL, in RST_PLL, drive `pll_rst`=1 for exactly RST_CYC cycles, then go to WAIT_LOCK with `tmr`=LOCK_TIMEOUT_CYC-1.
REQ-017 SHALL, in WAIT_LOCK, go to HOLDOFF with `tmr`=HOLDOFF_CYC-1 when `lk`=1.
REQ-018 SHALL, in WAIT_LOCK when `tmr` reaches 0 with `lk`=0, increment `retry_cnt`, then go to FAULT if the new value exceeds MAX_RETRY, else to RST_PLL.
REQ-019 SHALL make `lk` rising on the same cycle as timeout expiry take the lock path; no retry is counted.
REQ-020 SHALL, in HOLDOFF, return to WAIT_LOCK with the timeout reloaded if `lk`=0 (glitch, no loss counted), or go to RUN when `tmr` reaches 0 with `lk`=1.
REQ-021 SHALL register `clk_ready`=1 only in RUN, asserting on the first RUN cycle.
REQ-022 SHALL, in RUN, count consecutive `lk`=0 cycles, with the count cleared by any `lk`=1.
REQ-023 SHALL, in RUN, treat reaching LOSS_FILT_CYC as a lock loss: deassert `clk_ready` next cycle, increment `loss_cnt` (saturating), clear `retry_cnt`, go to RST_PLL.
REQ-024 SHALL ignore shorter lock dropouts in RUN.
REQ-025 SHALL, in FAULT, hold `pll_rst`=1, `clk_ready`=0 and `fault`=1; FAULT is left only via `rst_n`.
REQ-026 SHALL keep `pll_rst`=0 in every state except RST_PLL and FAULT.

Reset
REQ-027 SHALL, on `rst_n` low, asynchronously set state=RST_PLL, `tmr`=RST_CYC-1, synchronizer flops=0, loss filter=0, `pll_rst`=1, `clk_ready`=0, `fault`=0, `retry_cnt`=0 and `loss_cnt`=0.
REQ-028 SHALL release reset synchronously, with the RST_PLL pulse starting on the first clock after deassertion.
REQ-029 SHALL, on reset mid-operation (any state), abort immediately to the reset values; no counts are retained.

Structure
REQ-030 SHALL place the state enum `pll_ctrl_state_t` and default-parameter constants in package `clock_pkg`.
REQ-031 SHALL implement the 2-flop synchronizer as sub-module `sync_2ff`, reusable for other async status lines.
REQ-032 SHALL be all registered outputs; no combinational path from `pll_locked` to any output.

Verification (bench parameters: RST_CYC=4, LOCK_TIMEOUT_CYC=20, HOLDOFF_CYC=8, LOSS_FILT_CYC=3, MAX_RETRY=2)
REQ-033 SHALL cover nominal lock: `rst_n` released, `pll_locked` high 10 cycles later -> `pll_rst` high cycles 1-4, `clk_ready`=1 at 2 (sync) + 8 (holdoff) cycles after lock rises, `retry_cnt`=0.
REQ-034 SHALL cover timeout and retry: `pll_locked` held low -> three RST_PLL pulses spaced 24 cycles, then `fault`=1, `pll_rst` stuck high, `retry_cnt`=3.
REQ-035 SHALL cover the holdoff glitch: lock high 5 cycles, low 1 cycle, high -> `clk_ready` delayed by a full new holdoff, `loss_cnt`=0.
REQ-036 SHALL cover lock loss in RUN: a 2-cycle dropout leaves `clk_ready`=1; a 3-cycle dropout drops `clk_ready`, gives `loss_cnt`=1, and starts a new 4-cycle `pll_rst` pulse.
REQ-037 SHALL cover loss saturation: 256 forced losses -> `loss_cnt`=255.
REQ-038 SHALL cover reset mid-operation: `rst_n` pulsed low during HOLDOFF and during FAULT -> all outputs take their reset values asynchronously, and the sequence restarts.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clocking definitions: PLL lock controller state type and default timing constants.
package clock_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        HOLDOFF,
        RUN,
        FAULT
    } pll_ctrl_state_t;

    localparam int DEF_RST_CYC          = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 2700000;
    localparam int DEF_HOLDOFF_CYC      = 270;
    localparam int DEF_LOSS_FILT_CYC    = 4;
    localparam int DEF_MAX_RETRY        = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status line.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, reports readiness,
// retries on lock timeout, and counts lock losses while running.
module pll_lock_ctrl
    import clock_pkg::*;
#(
    parameter int RST_CYC          = DEF_RST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC      = DEF_HOLDOFF_CYC,
    parameter int LOSS_FILT_CYC    = DEF_LOSS_FILT_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic       clk_27m,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int TMR_MAX = max3(RST_CYC, LOCK_TIMEOUT_CYC, HOLDOFF_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int FILT_W  = (LOSS_FILT_CYC > 1) ? $clog2(LOSS_FILT_CYC + 1) : 1;

    localparam logic [TMR_W-1:0]  T_RST   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0]  T_LOCK  = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  T_HOLD  = TMR_W'(HOLDOFF_CYC - 1);
    localparam logic [FILT_W-1:0] F_LAST  = FILT_W'(LOSS_FILT_CYC - 1);
    localparam logic [3:0]        R_LIMIT = 4'(MAX_RETRY);

    logic            lk;
    pll_ctrl_state_t state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [FILT_W-1:0] filt, filt_nxt;
    logic [2:0]        retry_nxt;
    logic [7:0]        loss_nxt;
    logic [3:0]        retry_inc;

    sync_2ff u_lock_sync (
        .clk   (clk_27m),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_PLL;
            tmr       <= T_RST;
            filt      <= '0;
            pll_rst   <= 1'b1;
            clk_ready <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 3'd0;
            loss_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            filt      <= filt_nxt;
            pll_rst   <= (state_nxt == RST_PLL) || (state_nxt == FAULT);
            clk_ready <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        filt_nxt  = '0;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        retry_inc = {1'b0, retry_cnt} + 4'd1;
        case (state)
            RST_PLL: begin
                if (tmr == '0) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = T_LOCK;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the expiry cycle wins over the timeout
                if (lk) begin
                    state_nxt = HOLDOFF;
                    tmr_nxt   = T_HOLD;
                end else if (tmr == '0) begin
                    retry_nxt = (retry_inc > 4'd7) ? 3'd7 : retry_inc[2:0];
                    if (retry_inc > R_LIMIT) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = RST_PLL;
                        tmr_nxt   = T_RST;
                    end
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            HOLDOFF: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = T_LOCK;
                end else if (tmr == '0) begin
                    state_nxt = RUN;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            RUN: begin
                if (lk) begin
                    filt_nxt = '0;
                end else if (filt == F_LAST) begin
                    loss_nxt  = (loss_cnt == 8'hFF) ? 8'hFF : loss_cnt + 8'd1;
                    retry_nxt = 3'd0;
                    state_nxt = RST_PLL;
                    tmr_nxt   = T_RST;
                end else begin
                    filt_nxt = filt + 1'b1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RST_PLL;
                tmr_nxt   = T_RST;
            end
        endcase
    end

endmodule
